aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Iterative AES-128 key-schedule sequencer. It accepts a 128-bit cipher key over a valid/ready handshake and runs the 10 expansion rounds one per clock through a single shared round-step datapath. The 11 resulting round keys are held in an internal register file. The cipher core reads them by round index through a registered read port, so a full 11-instance unrolled schedule is not needed.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported.
KEY_W, 128, key and round-key width in bits, big-endian [0:KEY_W-1]; word w0 is bits [0:31].

Ports:
clk  in  1  system clock, rising-edge.
n_rst  in  1  asynchronous active-low reset.
key_in  in  [0:127]  cipher key; bits [0:7] are key byte 0.
key_valid  in  1  key_in is valid.
key_ready  out  1  block can accept a new key.
clear  in  1  synchronous abort/invalidate.
sched_valid  out  1  all 11 round keys are valid.
busy  out  1  expansion in progress.
rd_en  in  1  read strobe.
rd_round  in  4  round index to read, 0..10.
rd_key  out  [0:127]  round key for the index, registered.
rd_valid  out  1  rd_key is updated this cycle.

Behaviour:
- Reset (n_rst=0, async): state=IDLE; round_cnt=0; all 11 storage entries=0. Outputs: key_ready=1, sched_valid=0, busy=0, rd_key=0, rd_valid=0.
- States: IDLE, EXPAND, DONE.
- key_ready=1 in IDLE and DONE, 0 in EXPAND. busy=1 only in EXPAND. sched_valid=1 only in DONE.
- Accept: key_valid && key_ready && !clear at an edge (call it E0).
  - At E0: rk[0] <= key_in; round_cnt <= 1; state <= EXPAND; sched_valid drops.
- EXPAND: at edge Ei (i = 1..10), rk[i] <= step(rk[i-1], RCON[i-1]); round_cnt increments.
  - At E10: state <= DONE and sched_valid <= 1.
  - sched_valid is therefore high 10 cycles after the accept edge.
- key_valid during EXPAND is ignored; the key is not captured, and the requester must hold it until key_ready.
- DONE: holds the schedule indefinitely. A new accepted key restarts as from IDLE, and sched_valid falls at that same edge.
- clear=1 at an edge:
  - state <= IDLE, sched_valid <= 0, round_cnt <= 0. Storage is not zeroed.
  - clear has priority over a simultaneous key accept and aborts an EXPAND mid-run.
- Read port: at an edge with rd_en=1, rd_key <= rk[rd_round] and rd_valid <= 1 (1-cycle latency).
  - rd_round 11..15 returns all-zero with rd_valid=1.
  - rd_en=0 gives rd_valid <= 0 and rd_key holds.
  - Reads are legal in any state. Content is guaranteed only while sched_valid=1.
  - A read of entry i at the same edge entry i is written returns the old value.
- Round step (combinational):
  - temp = SubWord(RotWord(w3)) ^ {RCON,24'h0}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - All XOR, no carries.
- round_cnt is 4 bits and never exceeds 10; no wrap-around.

Decomposition:
- Package aes_pkg holds:
  - typedef round_key_t = logic [0:127].
  - typedef round_idx_t = logic [3:0].
  - constant RCON[0:9] = 01,02,04,08,10,20,40,80,1b,36.
  - SBOX[0:255] constant.
  - enum sched_state_t {IDLE, EXPAND, DONE}.
- One sub-module: aes_key_round, the purely combinational single-round step (round_key_t in, rcon byte in, round_key_t out), instantiated once.
- FSM, counter, register file and read port live in aes_key_sched_ctrl.

Test Plan:
- FIPS-197 key:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c, accept.
  - Response: sched_valid rises exactly 10 cycles later. rd_round=1 gives a0fafe1788542cb123a339392a6c7605 next cycle; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=0 returns the key.
- Backpressure:
  - Stimulus: assert key_valid with a second key during EXPAND.
  - Response: key_ready=0, key ignored. Accepted the cycle after DONE, and sched_valid drops that edge.
- Abort:
  - Stimulus: clear at cycle 5 of EXPAND.
  - Response: IDLE next edge, sched_valid=0, busy=0. Re-accepting the FIPS key reproduces correct round 10 after 10 cycles.
- Clear vs accept:
  - Stimulus: clear and key_valid in the same cycle while in DONE.
  - Response: key not captured, IDLE, sched_valid=0.
- Async reset:
  - Stimulus: n_rst low mid-EXPAND, asynchronously.
  - Response: outputs immediately at reset values; a read of rd_round=10 after release returns 0.
- Out-of-range read:
  - Stimulus: rd_round=11 and 15.
  - Response: rd_key=0, rd_valid=1. rd_en=0 the following cycle gives rd_valid=0 with rd_key held.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 key-schedule types, constants and the SubWord helper.
// Latency: none (declarations and a combinational function only).
// Backpressure: not applicable.
package aes_pkg;

    typedef logic [0:127] round_key_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } sched_state_t;

    // Round constants for expansion rounds 1..10, indexed by round-1.
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // S-box applied to each byte of a big-endian word.
    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round step: previous round key + RCON -> next round key.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to capture rk_out.
// Ports: rk_in (previous round key, big-endian), rcon (round constant byte),
//        rk_out (next round key).
module aes_key_round
    import aes_pkg::*;
(
    input  logic [0:127] rk_in,
    input  logic [7:0]   rcon,
    output logic [0:127] rk_out
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] temp;
    logic [0:31] n0, n1, n2, n3;

    assign w0 = rk_in[0:31];
    assign w1 = rk_in[32:63];
    assign w2 = rk_in[64:95];
    assign w3 = rk_in[96:127];

    // RotWord moves byte 0 of w3 to the end before substitution.
    assign temp = sub_word({w3[8:31], w3[0:7]}) ^ {rcon, 24'h000000};

    // Chained XOR: each new word folds in the one produced just before it.
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one expansion round per clock into an 11-entry round-key file.
// Latency: sched_valid 10 cycles after key accept; read port returns data 1 cycle after rd_en.
// Backpressure: key_ready low while expanding; key must be held until key_ready; clear aborts.
// Ports: clk/n_rst; key_in/key_valid/key_ready (key load handshake); clear (sync abort);
//        sched_valid/busy (status); rd_en/rd_round -> rd_key/rd_valid (registered read port).
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = 10,  // only 10 (AES-128) is supported
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             clear,
    output logic             sched_valid,
    output logic             busy,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [0:KEY_W-1] rd_key,
    output logic             rd_valid
);

    sched_state_t state_q, state_d;
    round_idx_t   cnt_q, cnt_d;
    round_key_t   rk_q [0:10];

    logic         wr_en;
    round_idx_t   wr_idx;
    round_key_t   wr_dat;

    round_idx_t   src_idx;
    round_key_t   step_out;

    // Round i is built from entry i-1; round_cnt is 1..10 whenever the step is used,
    // the zero guard only keeps the index in range while idle.
    assign src_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

    aes_key_round u_round (
        .rk_in  (rk_q[src_idx]),
        .rcon   (RCON[src_idx]),
        .rk_out (step_out)
    );

    assign key_ready   = (state_q != EXPAND);
    assign busy        = (state_q == EXPAND);
    assign sched_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_dat  = step_out;
        if (clear) begin
            // Abort wins over a simultaneous accept; storage is left as is.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (key_valid) begin
                        state_d = EXPAND;
                        cnt_d   = 4'd1;
                        wr_en   = 1'b1;
                        wr_idx  = 4'd0;
                        wr_dat  = key_in;
                    end
                end
                EXPAND: begin
                    wr_en = 1'b1;
                    // Counter parks at the last round rather than running past it.
                    if (cnt_q == round_idx_t'(NR)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 11; i++) begin
                rk_q[i] <= '0;
            end
        end else if (wr_en) begin
            rk_q[wr_idx] <= wr_dat;
        end
    end

    // Registered read: a same-edge write to the addressed entry is not visible yet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_key   <= (rd_round <= 4'd10) ? rk_q[rd_round] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: scoreboard on the read port plus direct status checks.
// Reference schedule is the textbook word-wise AES-128 expansion with a GF(2^8)-derived S-box.
// Runs directed (FIPS-197) and randomized keys through load, backpressure, abort, clear and reset cases.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         clear;
    logic         sched_valid;
    logic         busy;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   sb [0:255];
    logic [127:0] mdl [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_key_sched_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .clear       (clear),
        .sched_valid (sched_valid),
        .busy        (busy),
        .rd_en       (rd_en),
        .rd_round    (rd_round),
        .rd_key      (rd_key),
        .rd_valid    (rd_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Read-port monitor: every rd_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got rd_valid=1 key %h, expected no read", rd_key);
            end else begin
                chk("rd_key", rd_key, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] r, input logic [127:0] e);
        rd_en    = 1'b1;
        rd_round = r;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rd_mdl(input logic [3:0] r);
        rd(r, (r <= 4'd10) ? mdl[r] : 128'h0);
    endtask

    task automatic accept(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("accept_busy", {127'h0, busy}, 128'h1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (sched_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 128'(n), 128'd10);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        n_rst     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        clear     = 1'b0;
        rd_en     = 1'b0;
        rd_round  = 4'd0;
        build_sbox();
        for (int r = 0; r < 11; r++) mdl[r] = '0;

        #3;
        chk("rst_key_ready",   {127'h0, key_ready},   128'h1);
        chk("rst_sched_valid", {127'h0, sched_valid}, 128'h0);
        chk("rst_busy",        {127'h0, busy},        128'h0);
        chk("rst_rd_key",      rd_key,                128'h0);
        chk("rst_rd_valid",    {127'h0, rd_valid},    128'h0);
        #9 n_rst = 1'b1;
        tick();

        // FIPS-197 known-answer schedule.
        accept(FIPS_KEY);
        chk("fips_key_ready_low", {127'h0, key_ready}, 128'h0);
        wait_done("fips_latency");
        rd(4'd1, FIPS_R1);
        rd(4'd10, FIPS_R10);
        rd(4'd0, FIPS_KEY);
        expand(FIPS_KEY);
        rd_mdl(4'd5);

        // Backpressure: second key held during EXPAND, taken once DONE.
        a = rand128();
        b = rand128();
        expand(a);
        accept(a);
        key_in    = b;
        key_valid = 1'b1;
        #1;
        chk("bp_key_ready", {127'h0, key_ready}, 128'h0);
        wait_done("bp_latency_a");
        chk("bp_done_ready", {127'h0, key_ready}, 128'h1);
        rd(4'd0, mdl[0]);           // same edge as the write of entry 0: old value
        key_valid = 1'b0;
        chk("bp_accept_drop", {127'h0, sched_valid}, 128'h0);
        chk("bp_accept_busy", {127'h0, busy},        128'h1);
        expand(b);
        wait_done("bp_latency_b");
        rd_mdl(4'd10);
        rd_mdl(4'd4);

        // Abort mid-expansion, then reload.
        accept(FIPS_KEY);
        for (int i = 0; i < 4; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_sched_valid", {127'h0, sched_valid}, 128'h0);
        chk("abort_busy",        {127'h0, busy},        128'h0);
        chk("abort_key_ready",   {127'h0, key_ready},   128'h1);
        tick();
        tick();
        chk("abort_stays_idle",  {127'h0, busy},        128'h0);
        expand(FIPS_KEY);
        accept(FIPS_KEY);
        wait_done("abort_reload_latency");
        rd(4'd10, FIPS_R10);

        // Clear and accept together while DONE: clear wins.
        key_in    = rand128();
        key_valid = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        key_valid = 1'b0;
        chk("clracc_sched_valid", {127'h0, sched_valid}, 128'h0);
        chk("clracc_busy",        {127'h0, busy},        128'h0);
        chk("clracc_key_ready",   {127'h0, key_ready},   128'h1);
        tick();
        chk("clracc_no_start",    {127'h0, busy},        128'h0);
        rd(4'd0, FIPS_KEY);

        // Out-of-range reads and read hold.
        rd(4'd11, 128'h0);
        rd(4'd15, 128'h0);
        rd(4'd10, FIPS_R10);
        tick();
        chk("hold_rd_valid", {127'h0, rd_valid}, 128'h0);
        chk("hold_rd_key",   rd_key,             FIPS_R10);

        // Asynchronous reset in the middle of an expansion.
        accept(rand128());
        tick();
        tick();
        tick();
        #2 n_rst = 1'b0;
        #1;
        chk("arst_key_ready",   {127'h0, key_ready},   128'h1);
        chk("arst_sched_valid", {127'h0, sched_valid}, 128'h0);
        chk("arst_busy",        {127'h0, busy},        128'h0);
        chk("arst_rd_key",      rd_key,                128'h0);
        chk("arst_rd_valid",    {127'h0, rd_valid},    128'h0);
        #3 n_rst = 1'b1;
        for (int r = 0; r < 11; r++) mdl[r] = '0;
        tick();
        rd_mdl(4'd10);
        rd_mdl(4'd0);

        // Randomized keys against the reference expansion.
        for (int k = 0; k < 4; k++) begin
            a = rand128();
            expand(a);
            accept(a);
            wait_done("rand_latency");
            for (int j = 0; j < 3; j++) rd_mdl(4'($urandom_range(0, 10)));
            rd_mdl(4'($urandom_range(11, 15)));
        end

        tick();
        tick();
        tick();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
